// File: rtl/test_i4229.sv
// ---------------------------------------------------------------------------
// test_i4229 -- small sequential benchmark block with a hidden trigger.
//
// A 3-bit state (s0, s1, s2) feeds a Mealy output together with the current
// inputs. A 2-bit saturating counter tracks rising edges that sample the
// input pattern 1111. Once it reaches 3, the output is inverted until reset.
//
// Ports:
//   N0..N3        in   data inputs (N0 is the MSB of the bench vector N[0:3])
//   CK            in   clock, all state updates on the rising edge
//   reset         in   asynchronous active-low reset
//   output_single out  combinational output: golden function XOR armed flag
// ---------------------------------------------------------------------------
module test_i4229 (
  input  logic N0,
  input  logic N1,
  input  logic N2,
  input  logic N3,
  input  logic CK,
  input  logic reset,
  output logic output_single
);

  logic       r_s0;
  logic       r_s1;
  logic       r_s2;
  logic [1:0] r_tc;

  logic       w_s0_nxt;
  logic       w_s1_nxt;
  logic       w_s2_nxt;
  logic [1:0] w_tc_nxt;
  logic       w_all_ones;
  logic       w_golden;
  logic       w_armed;

  // State register: async clear, otherwise load the next-state values.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_tc <= 2'd0;
    end else begin
      r_s0 <= w_s0_nxt;
      r_s1 <= w_s1_nxt;
      r_s2 <= w_s2_nxt;
      r_tc <= w_tc_nxt;
    end
  end

  // Next-state logic; every right-hand side uses pre-edge register values.
  always_comb begin
    w_all_ones = N0 & N1 & N2 & N3;
    w_s0_nxt   = N0 ^ N3;
    w_s1_nxt   = (N1 & r_s0) | N2;
    w_s2_nxt   = ~(r_s1 ^ N3);
    // Counter only ever counts up and sticks at 3; other patterns hold it.
    if (w_all_ones && (r_tc != 2'd3)) begin
      w_tc_nxt = r_tc + 2'd1;
    end else begin
      w_tc_nxt = r_tc;
    end
  end

  // Output logic: Mealy golden function, inverted once the trigger is armed.
  // With all state cleared in reset this reduces to N1.
  always_comb begin
    w_golden = (r_s2 & N0) | (r_s1 ^ N1);
    if (r_tc == 2'd3) begin
      w_armed = 1'b1;
    end else begin
      w_armed = 1'b0;
    end
    output_single = w_golden ^ w_armed;
  end

endmodule

// File: tb/tb_test_i4229.sv
// ---------------------------------------------------------------------------
// tb_test_i4229 -- self-checking bench for test_i4229.
// A behavioural model (state vector plus an unbounded count of 1111 edges
// since reset) predicts the output; one compare process checks it on every
// falling clock edge, and directed literal checks pin both DUT and model.
// ---------------------------------------------------------------------------
module tb_test_i4229;

  logic N0, N1, N2, N3, CK, reset;
  logic output_single;

  int n_checks = 0;
  int n_fail   = 0;

  // model: st = {s2,s1,s0}, ones = number of 1111 edges since reset
  logic [2:0] m_st;
  int         m_ones;

  test_i4229 dut (
    .N0(N0), .N1(N1), .N2(N2), .N3(N3),
    .CK(CK), .reset(reset), .output_single(output_single)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  function automatic logic [3:0] cur_n();
    return {N0, N1, N2, N3};
  endfunction

  function automatic logic model_out(input logic [3:0] n);
    logic g;
    g = (m_st[2] & n[3]) | (m_st[1] ^ n[2]);
    return g ^ (m_ones >= 3);
  endfunction

  // model update on clock / async reset
  always @(posedge CK or negedge reset) begin
    logic [3:0] n;
    logic [2:0] nx;
    if (!reset) begin
      m_st   = 3'b000;
      m_ones = 0;
    end else begin
      n     = cur_n();
      nx[0] = n[3] ^ n[0];
      nx[1] = (n[2] & m_st[0]) | n[1];
      nx[2] = ~(m_st[1] ^ n[0]);
      m_st  = nx;
      if (n == 4'b1111 && m_ones < 100) m_ones = m_ones + 1;
    end
  end

  // single compare process: every falling edge
  always @(negedge CK) begin
    logic e;
    e = model_out(cur_n());
    n_checks = n_checks + 1;
    if (output_single !== e) begin
      n_fail = n_fail + 1;
      $display("FAIL cycle_cmp t=%0t N=%b got %b expected %b", $time, cur_n(), output_single, e);
    end
  end

  task automatic set_n(input logic [3:0] v);
    {N0, N1, N2, N3} = v;
  endtask

  // literal check of both DUT and model against a hand-computed value
  task automatic check_lit(input string name, input logic exp);
    logic m;
    #1;
    m = model_out(cur_n());
    n_checks = n_checks + 2;
    if (output_single !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s dut got %b expected %b", name, output_single, exp);
    end
    if (m !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s model got %b expected %b", name, m, exp);
    end
  endtask

  // advance past one rising edge with vector v applied before it
  task automatic edge_with(input logic [3:0] v);
    set_n(v);
    @(posedge CK);
    #2;
  endtask

  task automatic do_reset();
    @(posedge CK);
    #2;
    reset = 1'b0;
    @(posedge CK);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    set_n(4'b0100);
    check_lit("rst_follow_n1_hi", 1'b1);
    set_n(4'b0000);
    check_lit("rst_follow_n1_lo", 1'b0);
    repeat (2) @(posedge CK);
    #2;
    check_lit("rst_clock_ignored", 1'b0);
    reset = 1'b1;

    edge_with(4'b0000);
    check_lit("after_0000_n0000", 1'b0);
    set_n(4'b1000);
    check_lit("after_0000_n1000", 1'b1);

    do_reset();
    edge_with(4'b1000);
    check_lit("after_1000_held", 1'b1);

    do_reset();
    edge_with(4'b1111);
    check_lit("ones_edge1", 1'b0);
    edge_with(4'b1111);
    check_lit("ones_edge2", 1'b1);
    edge_with(4'b1111);
    check_lit("ones_edge3_armed", 1'b0);
    edge_with(4'b0000);
    check_lit("armed_0000_inverted", 1'b1);
    reset = 1'b0;
    check_lit("armed_reset_clears", 1'b0);
    @(posedge CK);
    #2;
    reset = 1'b1;
    edge_with(4'b1111);
    edge_with(4'b1111);
    check_lit("rearm_edge2_not_armed", 1'b1);
    edge_with(4'b1111);
    check_lit("rearm_edge3_armed", 1'b0);
    edge_with(4'b1111);
    check_lit("saturated_edge4", 1'b0);

    do_reset();
    edge_with(4'b1111);
    edge_with(4'b0000);
    edge_with(4'b1111);
    edge_with(4'b0101);
    set_n(4'b1111);
    check_lit("interleave_pre5_golden", 1'b1);
    edge_with(4'b1111);
    check_lit("interleave_post5_armed", 1'b1);
    set_n(4'b0000);
    check_lit("interleave_armed_0000", 1'b0);

    // randomized phase: 1111 biased, occasional mid-cycle reset pulses
    for (int i = 0; i < 3000; i++) begin
      @(posedge CK);
      #2;
      if (!reset) begin
        if ($urandom_range(0, 2) == 0) reset = 1'b1;
      end else if ($urandom_range(0, 79) == 0) begin
        reset = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) set_n(4'b1111);
      else set_n(4'($urandom_range(0, 15)));
    end

    @(posedge CK);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/test_i4229.md
# test_i4229

Benchmark sequential block with four single-bit inputs and one single-bit output, used as a device under analysis in the trojan-detection data set. A 3-bit state machine drives a combinational (Mealy) output. A hidden 2-bit trigger counter arms a payload after the rare input pattern 1111 has been seen on three rising clock edges. Once armed, the payload inverts the output until reset.

## Interface
- Parameters: none.
- Port order in the module header is fixed: N0, N1, N2, N3, CK, reset, output_single.
- CK  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. While 0, all state is held at reset values.
- N0  input  1  data input 0 (MSB of a bench vector N[0:3]).
- N1  input  1  data input 1.
- N2  input  1  data input 2.
- N3  input  1  data input 3 (LSB of a bench vector).
- output_single  output  1  combinational output derived from the state and the current inputs.

## Operation
- State registers: s0, s1, s2 (1 bit each) and a trigger counter tc (2 bits, saturating at 3).
- Next-state equations, evaluated on each rising CK when reset=1:
  - s0 <= N0 ^ N3
  - s1 <= (N1 & s0) | N2
  - s2 <= ~(s1 ^ N3)
  - tc <= (N0&N1&N2&N3 && tc!=3) ? tc+1 : tc
- All right-hand sides use pre-edge register values.
- The tc counter never decrements. Inputs other than 1111 leave tc unchanged; they do not clear it.
- Golden function: g = (s2 & N0) | (s1 ^ N1).
- armed = (tc == 3).
- output_single = g ^ armed.
- Reset (reset=0, asynchronous): s0=s1=s2=0 and tc=0, taking effect immediately and independent of CK.
  - During reset, output_single = N1, following N1 combinationally.
- No X-propagation: every register has a defined reset value.

## Timing
- The output is combinational: a change on any N input reaches output_single in the same cycle with no clock latency.
- A state change reaches the output immediately after the rising CK edge that loads it.
- The payload arms on the third rising edge with N=1111 since reset; the edges need not be consecutive. output_single inverts right after that edge.
- Reset assertion mid-cycle clears state and disarms the payload immediately.
- On reset deassertion, the first state update occurs at the next rising CK edge.
- If reset deasserts on the same edge as CK, that edge is ignored: state stays at reset values.
- tc is saturating: further 1111 edges after arming have no effect.

## Test plan
- Reset held low, N0..N3=0,1,0,0 -> output_single=1. Change N1 to 0 -> output_single=0 immediately, and CK toggling has no effect.
- Release reset. One edge with N=0000 -> state s0,s1,s2=0,0,1. Then:
  - N=0000 -> output 0.
  - N=1000 -> output 1 combinationally, before the next edge.
- After reset, one edge with N=1000 -> state 1,0,1 and output_single=1 with N=1000 held.
- After reset, hold N=1111 for three edges:
  - edge 1: output 0 (state 0,1,0).
  - edge 2: output 1 (state 0,1,1, tc=2).
  - edge 3: output 0 (armed, g=1 inverted).
- While armed, one edge with N=0000 -> state 0,0,0, g=0, output_single=1 (inverted). Then:
  - Pull reset low -> output_single=0 immediately (=N1).
  - After release, three more 1111 edges are required to re-arm.
- Interleave: 1111, 0000, 1111, 0101, 1111 on successive edges -> armed only after the fifth edge. Output before that edge equals the golden g.
